// File: rtl/data_unpack_if.sv
// -----------------------------------------------------------------------------
// data_unpack_if
// Bundles the signals shared by the unpack controller, the 32-bit-to-7-bit
// unpack datapath and the upstream word source.
//
//   word_valid  upstream word is present on the datapath's data_in
//   word_ready  controller accepts the word this cycle
//   count       datapath 5-bit bit-pointer
//   data_load   datapath load strobe
//   data_rst    datapath word-buffer clear (wins over data_load)
//   count_set   datapath pointer preset to 6
//   pkt_valid   datapath 7-bit packet output is valid this cycle
//
// Modports:
//   master  controller side (drives the strobes and the handshake response)
//   slave   datapath / word-source side
// -----------------------------------------------------------------------------
interface data_unpack_if;
   logic       word_valid;
   logic       word_ready;
   logic [4:0] count;
   logic       data_load;
   logic       data_rst;
   logic       count_set;
   logic       pkt_valid;

   modport master (
      input  word_valid,
      input  count,
      output word_ready,
      output data_load,
      output data_rst,
      output count_set,
      output pkt_valid
   );

   modport slave (
      output word_valid,
      output count,
      input  word_ready,
      input  data_load,
      input  data_rst,
      input  count_set,
      input  pkt_valid
   );
endinterface : data_unpack_if

// File: rtl/data_unpack_ctrl.sv
// -----------------------------------------------------------------------------
// data_unpack_ctrl
// Sequencing controller for the 32-bit-word to 7-bit-packet unpack datapath.
// The datapath pointer advances by 7 every cycle unless count_set is high, so
// there is no stall path: once running, a packet is emitted every cycle and a
// new word must be available whenever the pointer is about to wrap. A missing
// word is an underrun and forces a resync through IDLE.
//
// Parameters:
//   PKT_CNT_W  width of the free-running emitted-packet counter
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   enable     run request, sampled every cycle
//   clear_err  clears the sticky underrun flag (a same-cycle set wins)
//   bus        datapath / word-source handshake (master side)
//   busy       high while in RUN
//   underrun   sticky: a word was missing at a required load point
//   pkt_count  packets emitted, wraps modulo 2^PKT_CNT_W, cleared only by rst
// -----------------------------------------------------------------------------
module data_unpack_ctrl #(
   parameter int PKT_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear_err,
   data_unpack_if.master        bus,
   output logic                 busy,
   output logic                 underrun,
   output logic [PKT_CNT_W-1:0] pkt_count
);

   // One-hot encoding so that a corrupted state register is detectable and
   // falls into the recovery branch below.
   localparam logic [1:0] IDLE = 2'b01;
   localparam logic [1:0] RUN  = 2'b10;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       load_pt;
   logic       underrun_set;

   // The pointer needs a fresh word whenever count+7 would overflow 5 bits.
   assign load_pt = (bus.count >= 5'd25);

   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path can leave one unassigned and infer a latch.
      state_nxt      = state;
      bus.word_ready = 1'b0;
      bus.data_load  = 1'b0;
      bus.data_rst   = 1'b0;
      bus.count_set  = 1'b0;
      bus.pkt_valid  = 1'b0;
      busy           = 1'b0;
      underrun_set   = 1'b0;

      case (state)
         IDLE: begin
            // Hold the datapath parked: pointer at 6, word buffer empty.
            bus.count_set = 1'b1;
            bus.data_rst  = 1'b1;
            if (enable && bus.word_valid) begin
               // data_rst would override the load, so it must drop here.
               bus.word_ready = 1'b1;
               bus.data_load  = 1'b1;
               bus.data_rst   = 1'b0;
               state_nxt      = RUN;
            end
         end

         RUN: begin
            busy          = 1'b1;
            bus.pkt_valid = 1'b1;
            if (load_pt) begin
               if (!enable) begin
                  // Clean stop on a word boundary; residual bits are dropped.
                  bus.count_set = 1'b1;
                  bus.data_rst  = 1'b1;
                  state_nxt     = IDLE;
               end else if (bus.word_valid) begin
                  // Residual bits carry through the datapath overflow register.
                  bus.word_ready = 1'b1;
                  bus.data_load  = 1'b1;
               end else begin
                  // No word where one is required: flag and resync.
                  bus.count_set = 1'b1;
                  bus.data_rst  = 1'b1;
                  underrun_set  = 1'b1;
                  state_nxt     = IDLE;
               end
            end
         end

         default: begin
            // Illegal or unknown encoding: park the datapath and recover.
            bus.count_set = 1'b1;
            bus.data_rst  = 1'b1;
            state_nxt     = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         underrun  <= 1'b0;
         pkt_count <= '0;
      end else begin
         state <= state_nxt;

         // A new underrun outranks a simultaneous clear request.
         if (underrun_set) begin
            underrun <= 1'b1;
         end else if (clear_err) begin
            underrun <= 1'b0;
         end

         if (bus.pkt_valid) begin
            pkt_count <= pkt_count + PKT_CNT_W'(1);
         end
      end
   end

endmodule : data_unpack_ctrl

// File: tb/tb_data_unpack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_unpack_ctrl
// Scoreboard bench for data_unpack_ctrl. A small behavioural datapath (pointer
// plus bit buffer) closes the loop around the controller. Stimulus pushes the
// expected packets of each run; a negedge monitor pops and compares whenever
// pkt_valid is high.
// -----------------------------------------------------------------------------
module tb_data_unpack_ctrl;

   localparam int PKT_CNT_W = 16;

   typedef struct {
      logic [4:0] cnt;
      logic       wr;
      logic       stop;
      logic [6:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 enable = 1'b0;
   logic                 clear_err = 1'b0;
   logic                 word_valid = 1'b0;
   logic                 busy;
   logic                 underrun;
   logic [PKT_CNT_W-1:0] pkt_count;

   // Datapath model state.
   logic [4:0]  count_r = 5'd0;
   logic [63:0] bbuf = '0;
   int          nb = 0;
   int          widx = 0;

   int n_cmp = 0;
   int n_err = 0;
   exp_t exp_q[$];

   // Pointer sequence from start, straight from the datapath contract.
   int seq [32] = '{6, 13, 20, 27, 2, 9, 16, 23, 30, 5, 12, 19, 26, 1, 8, 15,
                    22, 29, 4, 11, 18, 25, 0, 7, 14, 21, 28, 3, 10, 17, 24, 31};

   logic [31:0] words [16] = '{
      32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0F0F_F0F0,
      32'hA5A5_5A5A, 32'h8000_0001, 32'h7654_3210, 32'h0000_0FFF,
      32'hFFFF_0000, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98,
      32'h3C3C_C3C3, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};

   data_unpack_if bus ();

   assign bus.count      = count_r;
   assign bus.word_valid = word_valid;

   data_unpack_ctrl #(.PKT_CNT_W(PKT_CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .clear_err (clear_err),
      .bus       (bus),
      .busy      (busy),
      .underrun  (underrun),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   // Behavioural datapath and upstream word source.
   always @(posedge clk) begin : dp_model
      logic [63:0] t;
      int          n;
      count_r <= (rst || bus.count_set) ? 5'd6 : count_r + 5'd7;
      t = bbuf;
      n = nb;
      if (bus.data_rst) begin
         t = '0;
         n = 0;
      end else begin
         if (bus.pkt_valid) begin
            t = t >> 7;
            n = (n >= 7) ? n - 7 : 0;
         end
         if (bus.data_load) begin
            t = t | (64'(words[widx % 16]) << n);
            n = n + 32;
         end
      end
      bbuf <= t;
      nb   <= n;
      if (word_valid && bus.word_ready) widx <= widx + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet k of a run that starts at word s: stream bits 7k..7k+6.
   function automatic logic [6:0] exp_pkt(input int s, input int k);
      logic [6:0]  r;
      logic [31:0] w;
      int          p;
      for (int b = 0; b < 7; b++) begin
         p    = 7 * k + b;
         w    = words[(s + p / 32) % 16];
         r[b] = w[p % 32];
      end
      return r;
   endfunction

   // Queue the n packets of a run starting at word s; stop_k marks the packet
   // on which the run ends (clean stop or underrun), -1 for none.
   task automatic push_run(input int s, input int n, input int stop_k);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.cnt  = 5'(seq[k]);
         e.stop = (k == stop_k);
         e.wr   = (seq[k] >= 25) && (k != stop_k);
         e.data = exp_pkt(s, k);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: compares every presented packet against the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      check("rst_load_excl", 32'(bus.data_rst & bus.data_load), 32'd0);
      if (bus.pkt_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pkt", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pkt_ptr", 32'(bus.count), 32'(e.cnt));
            check("pkt_word_ready", 32'(bus.word_ready), 32'(e.wr));
            check("pkt_data_load", 32'(bus.data_load), 32'(e.wr));
            check("pkt_count_set", 32'(bus.count_set), 32'(e.stop));
            check("pkt_data_rst", 32'(bus.data_rst), 32'(e.stop));
            check("pkt_data", 32'(bbuf[6:0]), 32'(e.data));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;

      // 1. Reset and idle.
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_count_set", 32'(bus.count_set), 32'd1);
      check("rst_data_rst", 32'(bus.data_rst), 32'd1);
      check("rst_word_ready", 32'(bus.word_ready), 32'd0);
      check("rst_ptr", 32'(count_r), 32'd6);

      // 2. Continuous stream of W0..W6, stop cleanly at pointer 31.
      step();
      push_run(0, 32, 31);
      enable     = 1'b1;
      word_valid = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         step();
         if (widx >= 7) enable = 1'b0;
         guard++;
      end
      drain(4);
      @(negedge clk);
      check("stream_busy", 32'(busy), 32'd0);
      check("stream_pkt_count", 32'(pkt_count), 32'd32);
      check("stream_words", 32'(widx), 32'd7);
      check("stream_underrun", 32'(underrun), 32'd0);

      // 4. Clean stop: enable dropped at pointer 13, fresh reset first.
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      push_run(widx, 4, 3);
      enable     = 1'b1;
      word_valid = 1'b1;
      step();
      step();
      enable = 1'b0;
      drain(10);
      @(negedge clk);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_pkt_count", 32'(pkt_count), 32'd4);
      check("stop_underrun", 32'(underrun), 32'd0);
      check("stop_ptr", 32'(count_r), 32'd6);
      check("stop_words", 32'(widx), 32'd8);

      // 3. Underrun at pointer 27, then a clean restart.
      step();
      push_run(widx, 4, 3);
      enable     = 1'b1;
      word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      drain(10);
      @(negedge clk);
      check("urun_flag", 32'(underrun), 32'd1);
      check("urun_busy", 32'(busy), 32'd0);
      check("urun_ptr", 32'(count_r), 32'd6);
      check("urun_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check("urun_words", 32'(widx), 32'd9);
      push_run(widx, 4, 3);
      word_valid = 1'b1;
      step();
      enable = 1'b0;
      drain(10);
      @(negedge clk);
      check("restart_sticky", 32'(underrun), 32'd1);
      check("restart_pkt_count", 32'(pkt_count), 32'd12);

      // 6. Error clear, then clear colliding with a new underrun.
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      @(negedge clk);
      check("clr_underrun", 32'(underrun), 32'd0);
      push_run(widx, 4, 3);
      enable     = 1'b1;
      word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      repeat (3) step();
      check("clr_at_ptr", 32'(count_r), 32'd27);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      @(negedge clk);
      check("clr_set_wins", 32'(underrun), 32'd1);
      check("clr_busy", 32'(busy), 32'd0);
      drain(2);

      // 5. Reset in the middle of a run at pointer 16.
      push_run(widx, 7, -1);
      word_valid = 1'b1;
      step();
      repeat (6) step();
      check("mrst_at_ptr", 32'(count_r), 32'd16);
      rst    = 1'b1;
      enable = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_pkt_count", 32'(pkt_count), 32'd0);
      check("mrst_underrun", 32'(underrun), 32'd0);
      check("mrst_data_rst", 32'(bus.data_rst), 32'd1);
      check("mrst_ptr", 32'(count_r), 32'd6);
      check("mrst_words", 32'(widx), 32'd13);
      @(negedge clk);
      check("mrst_buf_cleared", 32'(nb), 32'd0);
      drain(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_data_unpack_ctrl

// File: doc/data_unpack_ctrl.md
Name: data_unpack_ctrl

Overview:
Sequencing controller for the 32-bit-word to 7-bit-packet unpack datapath. It drives the datapath's data_rst, data_load and count_set strobes from the datapath's 5-bit bit-pointer count. It also runs a valid/ready handshake with the upstream word source and flags each cycle that presents a valid 7-bit packet downstream. The datapath pointer advances by 7 every cycle unless count_set is high, so the controller has no stall path: a late word is handled as an underrun and forces a resync.

Parameters:
PKT_CNT_W, 16, width of the free-running emitted-packet counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  run request; sampled every cycle
clear_err  in  1  clears the sticky underrun flag
word_valid  in  1  upstream word available on the datapath's data_in
word_ready  out  1  word accepted this cycle (transfer = word_valid & word_ready)
count  in  5  datapath bit-pointer
data_load  out  1  datapath load strobe
data_rst  out  1  datapath word-buffer clear
count_set  out  1  datapath pointer preset to 6
pkt_valid  out  1  datapath packet output is valid this cycle
busy  out  1  state == RUN
underrun  out  1  sticky; a word was missing at a required load point
pkt_count  out  PKT_CNT_W  packets emitted, wraps

Behaviour:
- States: IDLE, RUN. On rst: state=IDLE, underrun=0, pkt_count=0.
- Outputs are combinational from state, count, enable and word_valid.
- Datapath contract: data_rst and rst take priority over data_load, so data_rst must never be asserted in a cycle with data_load=1.
- IDLE:
  - Default outputs: count_set=1, data_rst=1, data_load=0, word_ready=0, pkt_valid=0, busy=0.
  - If enable & word_valid: word_ready=1, data_load=1, data_rst=0, count_set=1, next=RUN.
  - First pkt_valid is the cycle after acceptance, with count=6 (packet = word[6:0]). Latency from word accept to first packet: 1 cycle.
- RUN:
  - pkt_valid=1 every cycle; pkt_count increments on each pkt_valid cycle.
  - Load point: count >= 25, i.e. count+7 overflows 5 bits. No load is requested elsewhere, so word_ready=0 when count < 25.
  - Load point, enable=1, word_valid=1: word_ready=1, data_load=1, stay RUN. Residual bits carry through the datapath overflow register.
  - Load point, enable=1, word_valid=0 (underrun): packet still valid this cycle. Drive count_set=1, data_rst=1, set underrun, next=IDLE. Residual bits are discarded.
  - Load point, enable=0 (clean stop): packet valid this cycle. Drive count_set=1, data_rst=1, word_ready=0, next=IDLE. underrun is not set.
  - enable=0 at a non-load point: keep running until the next load point, then clean stop. Stops occur only on a word boundary.
- Pointer sequence from start: 6,13,20,27,2,9,16,23,30,5,12,19,26,1,8,15,22,29,4,11,18,25,0,7,14,21,28,3,10,17,24,31, then back to 6.
  - Loads occur at 27,30,26,29,25,28,31.
  - This gives 32 packets per 7 words, i.e. 224 bits with no loss.
- underrun: a set event and clear_err in the same cycle results in set.
- pkt_count: wraps modulo 2^PKT_CNT_W; cleared only by rst.
- rst mid-RUN: next cycle is IDLE with all registers at reset values. While in IDLE the controller itself drives count_set and data_rst, so the datapath resyncs.
- Illegal or unknown state encoding recovers to IDLE.

Test Plan:
1. Reset: rst=1 for 2 cycles, then idle with enable=0 -> pkt_valid=0, busy=0, underrun=0, pkt_count=0, count_set=1, data_rst=1, datapath count=6.
2. Continuous stream: enable=1, word_valid=1 always, 7 words W0..W6 -> first pkt_valid 1 cycle after W0 accept, count=6. word_ready pulses only at counts 27,30,26,29,25,28,31. 32 packets reassemble to W0..W6 exactly, and pkt_count=32.
3. Underrun: start, then word_valid=0 when count=27 -> pkt_valid=1 that cycle, count_set=1, data_rst=1, underrun=1, then IDLE with count=6 next cycle. Raising word_valid later restarts cleanly.
4. Clean stop: drop enable at count=13 -> packets at counts 20 and 27, then IDLE. word_ready never asserted, underrun=0, pkt_count=4.
5. Mid-run reset: rst at count=16 -> next cycle IDLE, pkt_valid=0, pkt_count=0. The datapath buffer is cleared via data_rst while IDLE.
6. Error clear: hold underrun=1, assert clear_err -> underrun=0 next cycle. Assert clear_err in the same cycle as a new underrun -> underrun stays 1.
